// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock (shift-subtract), start/done handshake.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands, adds a one-cycle FIX state).
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dvs_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   quotient_r;
  logic [WIDTH-1:0]   remainder_r;
  logic               dbz_r;
`ifdef DIV_SIGNED_EN
  logic               neg_q_r;
  logic               neg_r_r;
`endif

  logic [WIDTH:0]     r_shift_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   rem_step_s;
  logic [WIDTH-1:0]   quo_step_s;
  logic [WIDTH-1:0]   dvd_mag_s;
  logic [WIDTH-1:0]   dvs_mag_s;
  logic               last_iter_s;
  logic               div_zero_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

  assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
  assign div_zero_s  = (divisor == {WIDTH{1'b0}});

  // Operand magnitudes fed to the unsigned core
  always_comb begin
    dvd_mag_s = dividend;
    dvs_mag_s = divisor;
`ifdef DIV_SIGNED_EN
    if (dividend[WIDTH-1]) begin
      dvd_mag_s = negate(dividend);
    end else begin
      dvd_mag_s = dividend;
    end
    if (divisor[WIDTH-1]) begin
      dvs_mag_s = negate(divisor);
    end else begin
      dvs_mag_s = divisor;
    end
`endif
  end

  // One restoring iteration; the partial remainder stays below the divisor, so WIDTH bits hold it
  always_comb begin
    r_shift_s  = {rem_r, quo_r[WIDTH-1]};
    trial_s    = r_shift_s - {1'b0, dvs_r};
    rem_step_s = trial_s[WIDTH-1:0];
    quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
    if (trial_s[WIDTH]) begin
      rem_step_s = r_shift_s[WIDTH-1:0];
      quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_step_s = trial_s[WIDTH-1:0];
      quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (div_zero_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_CALC;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_iter_s) begin
`ifdef DIV_SIGNED_EN
          state_nxt_s = S_FIX;
`else
          state_nxt_s = S_DONE;
`endif
        end else begin
          state_nxt_s = S_CALC;
        end
      end
      S_FIX:   state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Working registers and result/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
`endif
    end else begin
      busy_r <= (state_nxt_s != S_IDLE);
      done_r <= (state_nxt_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            if (div_zero_s) begin
              quotient_r  <= {WIDTH{1'b1}};
              remainder_r <= dividend;
              dbz_r       <= 1'b1;
            end else begin
              dbz_r <= 1'b0;
              rem_r <= {WIDTH{1'b0}};
              quo_r <= dvd_mag_s;
              dvs_r <= dvs_mag_s;
              cnt_r <= {CNT_W{1'b0}};
`ifdef DIV_SIGNED_EN
              neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r_r <= dividend[WIDTH-1];
`endif
            end
          end
        end
        S_CALC: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          cnt_r <= cnt_r + CNT_W'(1);
`ifndef DIV_SIGNED_EN
          if (last_iter_s) begin
            quotient_r  <= quo_step_s;
            remainder_r <= rem_step_s;
          end
`endif
        end
        S_FIX: begin
`ifdef DIV_SIGNED_EN
          // Truncation toward zero: remainder follows the dividend's sign
          quotient_r  <= neg_q_r ? negate(quo_r) : quo_r;
          remainder_r <= neg_r_r ? negate(rem_r) : rem_r;
`else
          quotient_r  <= quo_r;
          remainder_r <= rem_r;
`endif
        end
        S_DONE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
